// File: rtl/bw_ctu_tsr_scan.sv
// ---------------------------------------------------------------------------
// bw_ctu_tsr_scan
// Sequential scan of the tempsensor test channels. For every channel the
// analog mux is switched, allowed to settle, the synchronized comparator
// output is counted over a programmable window, and the count is offered
// through a valid/ready result port. A done pulse marks the end of a scan.
//
// Optional feature: define CTU_TSR_ABORT_EN to add the abort input, which
// returns any active scan to IDLE on the next edge without a done pulse.
//
// Ports
//   jclk     in   clock, all state on rising edge
//   arst     in   asynchronous active-high reset
//   abort    in   scan abort (only with CTU_TSR_ABORT_EN)
//   start    in   single-cycle scan request, honoured in IDLE only
//   win      in   sample window in cycles, latched at start (0 acts as 1)
//   tsr_cmp  in   asynchronous comparator output from the pad
//   tsr_sel  out  one-hot analog mux select (all-zero in IDLE)
//   busy     out  high whenever the FSM is not in IDLE
//   res_vld  out  result valid
//   res_rdy  in   result accepted
//   res_ch   out  channel of the current result
//   res_cnt  out  sampled-high cycles in the window
//   done     out  one-cycle pulse after the last result is accepted
// ---------------------------------------------------------------------------
module bw_ctu_tsr_scan #(
  parameter int unsigned CH_W   = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SETTLE = 16
) (
  input  logic                   jclk,
  input  logic                   arst,
`ifdef CTU_TSR_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [CNT_W-1:0]       win,
  input  logic                   tsr_cmp,
  output logic [(2**CH_W)-1:0]   tsr_sel,
  output logic                   busy,
  output logic                   res_vld,
  input  logic                   res_rdy,
  output logic [CH_W-1:0]        res_ch,
  output logic [CNT_W-1:0]       res_cnt,
  output logic                   done
);

  localparam int unsigned NCH   = 2**CH_W;
  localparam int unsigned SET_W = 8;
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CH_W-1:0]    r_ch, w_ch_nxt;
  logic [SET_W-1:0]   r_scnt, w_scnt_nxt;
  logic [CNT_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0]   r_win, w_win_nxt;
  logic [CNT_W-1:0]   r_ones, w_ones_nxt;
  logic [CH_W-1:0]    r_res_ch, w_res_ch_nxt;
  logic [CNT_W-1:0]   r_res_cnt, w_res_cnt_nxt;
  logic               w_done_nxt;
  logic               w_abort;
  logic [CNT_W-1:0]   w_ones_inc;

  logic               r_sync1, r_sync2;
  logic [NCH-1:0]     r_sel;
  logic               r_busy, r_res_vld, r_done;

`ifdef CTU_TSR_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge jclk or posedge arst) begin
    if (arst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= tsr_cmp;
      r_sync2 <= r_sync1;
    end
  end

  // Running count including this cycle's synchronized sample
  assign w_ones_inc = r_ones + {{(CNT_W-1){1'b0}}, r_sync2};

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt   = r_state;
    w_ch_nxt      = r_ch;
    w_scnt_nxt    = r_scnt;
    w_wcnt_nxt    = r_wcnt;
    w_win_nxt     = r_win;
    w_ones_nxt    = r_ones;
    w_res_ch_nxt  = r_res_ch;
    w_res_cnt_nxt = r_res_cnt;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_ch_nxt    = '0;
          w_scnt_nxt  = SETTLE_LD;
          w_win_nxt   = (win == '0) ? CNT_W'(1) : win;
        end
      end
      ST_SETTLE: begin
        if (r_scnt == '0) begin
          w_state_nxt = ST_SAMPLE;
          w_ones_nxt  = '0;
          w_wcnt_nxt  = r_win - CNT_W'(1);
        end else begin
          w_scnt_nxt = r_scnt - SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        w_ones_nxt = w_ones_inc;
        if (r_wcnt == '0) begin
          w_state_nxt   = ST_REPORT;
          w_res_ch_nxt  = r_ch;
          w_res_cnt_nxt = w_ones_inc;
        end else begin
          w_wcnt_nxt = r_wcnt - CNT_W'(1);
        end
      end
      ST_REPORT: begin
        if (res_rdy) begin
          if (r_ch == CH_LAST) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_ch_nxt    = r_ch + CH_W'(1);
            w_scnt_nxt  = SETTLE_LD;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort outranks the result handshake and never produces done
    if (w_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge jclk or posedge arst) begin
    if (arst) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_scnt    <= '0;
      r_wcnt    <= '0;
      r_win     <= '0;
      r_ones    <= '0;
      r_res_ch  <= '0;
      r_res_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ch      <= w_ch_nxt;
      r_scnt    <= w_scnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_win     <= w_win_nxt;
      r_ones    <= w_ones_nxt;
      r_res_ch  <= w_res_ch_nxt;
      r_res_cnt <= w_res_cnt_nxt;
    end
  end

  // Output registers follow the next state so they line up with r_state
  always_ff @(posedge jclk or posedge arst) begin
    if (arst) begin
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_res_vld <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sel     <= (w_state_nxt != ST_IDLE) ? (NCH'(1) << w_ch_nxt) : '0;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_res_vld <= (w_state_nxt == ST_REPORT);
      r_done    <= w_done_nxt;
    end
  end

  assign tsr_sel = r_sel;
  assign busy    = r_busy;
  assign res_vld = r_res_vld;
  assign res_ch  = r_res_ch;
  assign res_cnt = r_res_cnt;
  assign done    = r_done;

endmodule

// File: tb/tb_bw_ctu_tsr_scan.sv
// ---------------------------------------------------------------------------
// tb_bw_ctu_tsr_scan
// Self-checking bench for bw_ctu_tsr_scan with default parameters. Expected
// results are queued when a scan is launched and compared on each result
// handshake. Full scans come from a vector table; backpressure, reset,
// start-on-done and abort are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_bw_ctu_tsr_scan;

  logic       jclk = 1'b0;
  logic       arst;
  logic       start;
  logic [7:0] win;
  logic       tsr_cmp;
  logic       res_rdy;
  logic       abort_i;
  logic [3:0] tsr_sel;
  logic       busy;
  logic       res_vld;
  logic [1:0] res_ch;
  logic [7:0] res_cnt;
  logic       done;

  bw_ctu_tsr_scan dut (
    .jclk    (jclk),
    .arst    (arst),
`ifdef CTU_TSR_ABORT_EN
    .abort   (abort_i),
`endif
    .start   (start),
    .win     (win),
    .tsr_cmp (tsr_cmp),
    .tsr_sel (tsr_sel),
    .busy    (busy),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .res_ch  (res_ch),
    .res_cnt (res_cnt),
    .done    (done)
  );

  always #5 jclk = ~jclk;

  int checks   = 0;
  int failures = 0;
  int cmp_mode = 0;  // 0: constant low, 1: constant high, 2: toggle

  typedef struct { int ch; int cnt; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] win;
    int         mode;
    int         exp_cnt;
    int         exp_busy;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge jclk);
    #1;
  endtask

  task automatic push_scan(input int cnt);
    for (int c = 0; c < 4; c++) begin
      exp_t e;
      e.ch  = c;
      e.cnt = cnt;
      sb.push_back(e);
    end
  endtask

  task automatic wait_vld(input int ch);
    int n = 0;
    while (!(res_vld && res_ch == 2'(ch)) && n < 2000) begin
      tick();
      n++;
    end
    chk("wait_vld", {63'd0, res_vld}, 64'd1);
  endtask

  task automatic wait_sel(input logic [3:0] sel);
    int n = 0;
    while (tsr_sel != sel && n < 2000) begin
      tick();
      n++;
    end
    chk("wait_sel", 64'(tsr_sel), 64'(sel));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    chk("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  // One full scan; counts busy cycles and checks the done pulse width
  task automatic run_scan(input vec_t v);
    int n = 0;
    cmp_mode = v.mode;
    push_scan(v.exp_cnt);
    win   = v.win;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && n < 5000) begin
      n++;
      tick();
    end
    chk("busy_cycles", 64'(n), 64'(v.exp_busy));
    chk("done_high", {63'd0, done}, 64'd1);
    chk("sel_idle", 64'(tsr_sel), 64'd0);
    tick();
    chk("done_width", {63'd0, done}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Comparator stimulus, updated just after each rising edge
  initial begin
    tsr_cmp = 1'b0;
    forever begin
      @(posedge jclk);
      #1;
      case (cmp_mode)
        1:       tsr_cmp = 1'b1;
        2:       tsr_cmp = ~tsr_cmp;
        default: tsr_cmp = 1'b0;
      endcase
    end
  end

  // Result monitor: scoreboard pop on handshake, hold and select checks
  logic       pv = 1'b0, pr = 1'b0;
  logic [1:0] pch = '0;
  logic [7:0] pcnt = '0;
  initial begin
    forever begin
      @(negedge jclk);
      if (!arst) begin
        if (pv && !pr) begin
          chk("hold_vld", {63'd0, res_vld}, 64'd1);
          chk("hold_ch", 64'(res_ch), 64'(pch));
          chk("hold_cnt", 64'(res_cnt), 64'(pcnt));
        end
        if (res_vld)
          chk("sel_match", 64'(tsr_sel), 64'(4'b0001 << res_ch));
        if (res_vld && res_rdy && !abort_i) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=ch%0d required=none", res_ch);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_ch", 64'(res_ch), 64'(e.ch));
            chk("res_cnt", 64'(res_cnt), 64'(e.cnt));
          end
        end
        pv = res_vld;
      end else begin
        pv = 1'b0;
      end
      pr   = res_rdy;
      pch  = res_ch;
      pcnt = res_cnt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'd10,  1, 10,  108};
    vt[1] = '{8'd0,   0, 0,   72};
    vt[2] = '{8'd8,   2, 4,   100};
    vt[3] = '{8'd0,   1, 1,   72};
    vt[4] = '{8'd255, 1, 255, 1088};
    vt[5] = '{8'd5,   0, 0,   88};

    arst    = 1'b1;
    start   = 1'b0;
    win     = 8'd0;
    res_rdy = 1'b1;
    abort_i = 1'b0;
    repeat (3) tick();

    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sel", 64'(tsr_sel), 64'd0);
    chk("rst_vld", {63'd0, res_vld}, 64'd0);
    chk("rst_ch", 64'(res_ch), 64'd0);
    chk("rst_cnt", 64'(res_cnt), 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    arst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_scan(vt[i]);

    // Backpressure: hold the ch1 result for 20 cycles
    cmp_mode = 1;
    push_scan(3);
    res_rdy = 1'b0;
    win     = 8'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_vld(0);
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    wait_vld(1);
    repeat (20) begin
      tick();
      chk("bp_sel_ch1", 64'(tsr_sel), 64'd2);
    end
    chk("bp_vld", {63'd0, res_vld}, 64'd1);
    res_rdy = 1'b1;
    tick();
    chk("bp_sel_ch2", 64'(tsr_sel), 64'd4);
    chk("bp_vld_drop", {63'd0, res_vld}, 64'd0);
    wait_idle();
    chk("bp_done", {63'd0, done}, 64'd1);
    chk("bp_sb", 64'(sb.size()), 64'd0);
    sb.delete();
    tick();

    // Start in the same cycle as done is accepted
    cmp_mode = 0;
    push_scan(0);
    win   = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 5000) begin
        tick();
        n++;
      end
    end
    chk("sd_done", {63'd0, done}, 64'd1);
    cmp_mode = 1;
    push_scan(2);
    win   = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sd_busy", {63'd0, busy}, 64'd1);
    chk("sd_sel", 64'(tsr_sel), 64'd1);
    chk("sd_done_gone", {63'd0, done}, 64'd0);
    wait_idle();
    chk("sd_done2", {63'd0, done}, 64'd1);
    chk("sd_sb", 64'(sb.size()), 64'd0);
    sb.delete();
    tick();

    // Reset during SAMPLE of ch2; a start mid-scan is ignored
    cmp_mode = 1;
    push_scan(10);
    win   = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sel(4'b0010);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start", 64'(tsr_sel), 64'd2);
    wait_sel(4'b0100);
    repeat (18) tick();
    #2;
    arst = 1'b1;
    #1;
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_sel", 64'(tsr_sel), 64'd0);
    chk("ar_vld", {63'd0, res_vld}, 64'd0);
    chk("ar_ch", 64'(res_ch), 64'd0);
    chk("ar_cnt", 64'(res_cnt), 64'd0);
    chk("ar_done", {63'd0, done}, 64'd0);
    chk("ar_sb_left", 64'(sb.size()), 64'd2);
    sb.delete();
    tick();
    arst = 1'b0;
    repeat (5) tick();
    chk("ar_idle", {63'd0, busy}, 64'd0);
    run_scan('{8'd4, 1, 4, 84});

`ifdef CTU_TSR_ABORT_EN
    // Abort in REPORT wins over a simultaneous handshake
    cmp_mode = 1;
    push_scan(2);
    res_rdy = 1'b0;
    win     = 8'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_vld(0);
    res_rdy = 1'b1;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("ab_busy", {63'd0, busy}, 64'd0);
    chk("ab_vld", {63'd0, res_vld}, 64'd0);
    chk("ab_sel", 64'(tsr_sel), 64'd0);
    chk("ab_done", {63'd0, done}, 64'd0);
    tick();
    chk("ab_done2", {63'd0, done}, 64'd0);
    chk("ab_sb", 64'(sb.size()), 64'd4);
    sb.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
